// File: rtl/wide_item_serializer.sv
// Serializes one WIDTH-bit item from the wide FIFO into WIDTH/WORD words on an enq client, 1 word/cycle sustained.
// Define WIDE_SER_MSB_FIRST_EN to emit words MSB first (default LSB first); out_enq_rdy low stalls the shift and dequeue.
module wide_item_serializer #(
    parameter int WIDTH = 704,
    parameter int WORD  = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] in_first,
    input  logic             in_first_rdy,
    input  logic             in_deq_rdy,
    output logic             in_deq_ena,
    output logic [WORD-1:0]  out_enq_v,
    output logic             out_enq_ena,
    input  logic             out_enq_rdy,
    output logic             out_last,
    output logic             busy
);
    localparam int BEATS = WIDTH / WORD;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        if (((WIDTH % WORD) != 0) || (WIDTH < WORD)) begin : g_bad_width
            $error("wide_item_serializer: WIDTH must be a nonzero multiple of WORD");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [BW-1:0]    r_beat, w_beat_nxt;
    logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [WORD-1:0]  w_head;
    logic             w_busy;
    logic             w_ena;
    logic             w_last_beat;
    logic             w_last;
    logic             w_load;

`ifdef WIDE_SER_MSB_FIRST_EN
    assign w_head    = r_sreg[WIDTH-1 -: WORD];
    assign w_shifted = r_sreg << WORD;
`else
    assign w_head    = r_sreg[WORD-1:0];
    assign w_shifted = r_sreg >> WORD;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_sreg  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_sreg  <= w_sreg_nxt;
        end
    end

    // Outputs are masked while nRST is low so nothing leaks out during the reset cycle itself.
    always_comb begin
        w_busy      = nRST && (r_state == SEND);
        w_ena       = w_busy && out_enq_rdy;
        w_last_beat = (r_beat == LAST_BEAT);
        w_last      = w_ena && w_last_beat;
        w_load      = nRST && in_first_rdy && in_deq_rdy && (!w_busy || w_last);

        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_sreg_nxt  = r_sreg;

        if (w_load) begin
            w_sreg_nxt  = in_first;
            w_beat_nxt  = '0;
            w_state_nxt = SEND;
        end else if (w_ena) begin
            w_sreg_nxt = w_shifted;
            if (w_last_beat) begin
                w_beat_nxt  = '0;
                w_state_nxt = IDLE;
            end else begin
                w_beat_nxt = r_beat + BW'(1);
            end
        end
    end

    assign out_enq_ena = w_ena;
    assign out_enq_v   = w_ena ? w_head : '0;
    assign out_last    = w_last;
    assign in_deq_ena  = w_load;
    assign busy        = w_busy;

endmodule

// File: doc/wide_item_serializer.md
Name: wide_item_serializer

Overview:
- Downstream consumer of the ping-pong wide FIFO stage. Dequeues one WIDTH-bit item from the FIFO's first/deq server and emits it as WIDTH/WORD narrow words on an enq-style client.
- Feeds the narrow indication/transport path, which carries 32-bit words.
- Dequeues the next item on the same cycle the previous item's last word is accepted, so back-to-back items stream without bubbles.

Parameters:
- WIDTH, 704, item width in bits; must be an exact multiple of WORD (elaboration error otherwise).
- WORD, 32, output word width in bits.
- BEATS is derived, not overridable: WIDTH/WORD (22 at defaults). Beat counter width = $clog2(BEATS), minimum 1.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- in_first  in  WIDTH  head item of upstream FIFO
- in_first_rdy  in  1  in_first valid
- in_deq_rdy  in  1  upstream can dequeue
- in_deq_ena  out  1  dequeue strobe; high only when in_deq_rdy && in_first_rdy
- out_enq_v  out  WORD  word payload; 0 when out_enq_ena low
- out_enq_ena  out  1  word transfer strobe; high only when out_enq_rdy
- out_enq_rdy  in  1  downstream can accept
- out_last  out  1  current word is the item's final beat; 0 when out_enq_ena low
- busy  out  1  item held in shift register

Behaviour:
- State: busy flag (IDLE = 0 / SEND = 1), beat counter, WIDTH-bit shift register sreg.
- Reset (nRST low at posedge): busy=0, beat=0, sreg=0. In the reset cycle and after it, out_enq_ena=0, out_enq_v=0, out_last=0, in_deq_ena=0, busy=0. Reset mid-item discards the remainder of that item; the upstream item already dequeued is lost. No partial words are emitted after reset.
- Combinational outputs:
  - out_enq_ena = busy && out_enq_rdy.
  - last_beat = (beat == BEATS-1).
  - out_last = out_enq_ena && last_beat.
  - load = in_first_rdy && in_deq_rdy && (!busy || out_last).
  - in_deq_ena = load.
  - out_enq_v = out_enq_ena ? sreg[WORD-1:0] : 0.
- Sequential, priority order:
  - If load: sreg <= in_first, beat <= 0, busy <= 1.
  - Else if out_enq_ena: sreg <= sreg >> WORD (zero fill), beat <= beat+1; if last_beat, busy <= 0 and beat <= 0.
- Word order (default): LSB first. Beat k carries in_first[k*WORD +: WORD].
- Latency: first word is presented on out_enq_v the cycle after load. An item takes BEATS cycles under no backpressure.
- Throughput: the last beat and the next load coincide, giving 1 word/cycle sustained with no idle cycle between items.
- Backpressure: while out_enq_rdy is low, sreg, beat and busy hold and nothing is dequeued.
- Upstream not ready: in_first_rdy=1 with in_deq_rdy=0 produces no load. The block remains IDLE, or goes IDLE after the last beat.
- in_first is sampled only on the load cycle; later changes are ignored.
- Beat counter never exceeds BEATS-1; no wrap past it.

Optional Feature:
- Macro: WIDE_SER_MSB_FIRST_EN.
- Defined: words are emitted MSB first. Beat k carries in_first[WIDTH-1-k*WORD -: WORD]; out_enq_v = sreg[WIDTH-1 -: WORD]; shift is sreg << WORD. All handshake and timing behaviour is unchanged.
- Undefined: LSB-first ordering as above.

Test Plan:
- Single item, WIDTH=704/WORD=32, word i = 32'hA000_0000+i, out_enq_rdy=1 -> 22 consecutive beats 0xA0000000..0xA0000015. out_last only on beat 21. in_deq_ena pulses once.
- Two items queued back-to-back (words 0xA0.., 0xB0..) -> 44 consecutive out_enq_ena cycles with no gap. in_deq_ena high at cycle 0 and at the cycle of beat 21. Second item starts with 0xB0000000.
- out_enq_rdy pattern 1,0,0,1,0,1... during an item -> out_enq_v values stay in order with no loss or duplication. out_enq_ena is never high while out_enq_rdy is low. Total 22 beats.
- in_first_rdy=1, in_deq_rdy=0 for 5 cycles, then 1 -> no in_deq_ena and busy=0 for those 5 cycles. Load occurs on the first cycle in_deq_rdy=1.
- nRST low for 1 cycle after beat 10 of an item -> busy=0, no further words from that item. Next item begins at its word 0 with beat counter 0.
- Build with WIDE_SER_MSB_FIRST_EN, item word i = i -> beats emitted 21,20,...,0. out_last on the word with value 0.
